// File: rtl/wb_regfile_writer.sv
// Write-back initiator for the integer register file write port.
// Retired results from EXU/LSU are queued in a small in-order FIFO. The head
// entry drives the register file handshake and stays stable until it is
// accepted. Non-writing entries (wen=0 or rd=0) pass through without touching
// the register file. Each pop produces a registered commit pulse. Decode gets
// "busy" flags for source registers that still have a write pending.
module wb_regfile_writer #(
  parameter int DEPTH      = 2,
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_wen,
  input  logic [ADDR_WIDTH-1:0]    in_rd,
  input  logic [DATA_WIDTH-1:0]    in_data,
  input  logic [31:0]              in_pc,
  output logic                     rf_valid,
  input  logic                     rf_ready,
  output logic [ADDR_WIDTH-1:0]    rf_waddr,
  output logic [DATA_WIDTH-1:0]    rf_wdata,
  input  logic [ADDR_WIDTH-1:0]    hz_raddr1,
  input  logic [ADDR_WIDTH-1:0]    hz_raddr2,
  output logic                     hz_busy1,
  output logic                     hz_busy2,
  output logic                     commit_valid,
  output logic [31:0]              commit_pc,
  output logic [$clog2(DEPTH):0]   pending_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // FIFO storage. Kept in flops: the hazard lookup needs every entry at once.
  logic                  entry_wen_reg  [DEPTH];
  logic [ADDR_WIDTH-1:0] entry_rd_reg   [DEPTH];
  logic [DATA_WIDTH-1:0] entry_data_reg [DEPTH];
  logic [31:0]           entry_pc_reg   [DEPTH];

  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;

  logic        commit_valid_reg;
  logic [31:0] commit_pc_reg;

  logic full;
  logic empty;
  logic push;
  logic pop;
  logic in_wen_eff;
  logic head_wen;

  logic [DEPTH-1:0] match1;
  logic [DEPTH-1:0] match2;

  assign full       = (count_reg == CNT_W'(DEPTH));
  assign empty      = (count_reg == '0);
  assign in_wen_eff = in_wen && (in_rd != '0);
  assign head_wen   = entry_wen_reg[rd_ptr_reg];

  // No push while full, even when the head pops in the same cycle.
  assign in_ready = !reset && !full;
  assign push     = in_valid && in_ready;

  // Writing heads wait for the register file; non-writing heads drop at once.
  assign rf_valid = !reset && !empty && head_wen;
  assign rf_waddr = entry_rd_reg[rd_ptr_reg];
  assign rf_wdata = entry_data_reg[rd_ptr_reg];
  assign pop      = !empty && (head_wen ? rf_ready : 1'b1);

  assign pending_cnt  = count_reg;
  assign commit_valid = commit_valid_reg;
  assign commit_pc    = commit_pc_reg;

  // Occupancy update: simultaneous push and pop leaves the count unchanged.
  always_comb begin
    count_next = count_reg;
    if (push && !pop) begin
      count_next = count_reg + CNT_W'(1);
    end else if (pop && !push) begin
      count_next = count_reg - CNT_W'(1);
    end
  end

  // Pointers, occupancy and the registered commit pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_reg       <= '0;
      rd_ptr_reg       <= '0;
      count_reg        <= '0;
      commit_valid_reg <= 1'b0;
      commit_pc_reg    <= '0;
    end else begin
      count_reg        <= count_next;
      commit_valid_reg <= pop;
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_reg    <= rd_ptr_reg + PTR_W'(1);
        commit_pc_reg <= entry_pc_reg[rd_ptr_reg];
      end
    end
  end

  // Entry payload; validity is tracked by count_reg so no reset is needed.
  always_ff @(posedge clock) begin
    if (push) begin
      entry_wen_reg[wr_ptr_reg]  <= in_wen_eff;
      entry_rd_reg[wr_ptr_reg]   <= in_rd;
      entry_data_reg[wr_ptr_reg] <= in_data;
      entry_pc_reg[wr_ptr_reg]   <= in_pc;
    end
  end

  // Per-entry hazard match: an entry is live when its distance from the read
  // pointer is below the occupancy, so stale slots never raise a flag.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_hazard
      logic [PTR_W-1:0] offset;
      logic             live;
      assign offset     = PTR_W'(gi) - rd_ptr_reg;
      assign live       = (CNT_W'(offset) < count_reg) && entry_wen_reg[gi];
      assign match1[gi] = live && (entry_rd_reg[gi] == hz_raddr1);
      assign match2[gi] = live && (entry_rd_reg[gi] == hz_raddr2);
    end
  endgenerate

  assign hz_busy1 = (hz_raddr1 != '0) && (|match1);
  assign hz_busy2 = (hz_raddr2 != '0) && (|match2);

endmodule
